// File: rtl/dpb_pkg.sv
// Shared definitions for the dual-port-buffer / ping-pong-FIFO bridge front end.
package dpb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_ARM_RX = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_CANCEL = 3'd5
  } dpb_state_e;

  // BRAM read settle time used by the bridge
  localparam int unsigned MEM_WAIT = 4;

endpackage

// File: rtl/dpb_stream_loader_sync_bit.sv
// Two-flop synchroniser for a single asynchronous level.
module sync_bit (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/dpb_stream_loader.sv
// clk-domain front end for the DPB/PPFIFO bridge: streams words into the BRAM
// for TX, and drains bridge-filled BRAM contents to an output stream for RX.
module dpb_stream_loader
  import dpb_pkg::*;
#(
  parameter int unsigned MEM_DEPTH  = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IDLE_GUARD = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_tx_start,
  input  logic [MEM_DEPTH:0]    i_tx_count,
  input  logic                  i_rx_start,
  input  logic [MEM_DEPTH:0]    i_rx_count,
  input  logic                  i_cancel,
  output logic                  o_busy,
  output logic                  o_done,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [DATA_WIDTH-1:0] i_in_data,
  input  logic                  i_in_last,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [DATA_WIDTH-1:0] o_out_data,
  output logic                  o_out_last,
  output logic                  o_bram_we,
  output logic [MEM_DEPTH-1:0]  o_bram_addr,
  output logic [DATA_WIDTH-1:0] o_bram_din,
  input  logic [DATA_WIDTH-1:0] i_bram_dout,
  input  logic                  i_bram_valid,
  output logic                  o_mem_2_ppfifo_stb,
  output logic                  o_ppfifo_2_mem_en,
  output logic                  o_cancel_write_stb,
  input  logic                  i_bridge_idle
);

  localparam int unsigned    CW    = MEM_DEPTH + 1;
  localparam int unsigned    GW    = $clog2(IDLE_GUARD + 2);
  localparam logic [CW-1:0]  FULL  = CW'(2 ** MEM_DEPTH);
  localparam logic [GW-1:0]  GUARD = GW'(IDLE_GUARD);

  logic idle_s;

  sync_bit u_idle_sync (
    .clk (clk),
    .rst (rst),
    .d   (i_bridge_idle),
    .q   (idle_s)
  );

  dpb_state_e            state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         wcnt_q, wcnt_d;
  logic [CW-1:0]         rcnt_q, rcnt_d;
  logic [GW-1:0]         guard_q, guard_d;
  logic                  seen_busy_q, seen_busy_d;
  logic                  blank_q, blank_d;
  logic                  done_q, done_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic                  we_q, we_d;
  logic [MEM_DEPTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  stb_q, stb_d;
  logic                  en_q, en_d;
  logic                  cancel_stb_q, cancel_stb_d;

  logic [CW-1:0] req_count;
  logic [CW-1:0] sat_count;
  logic [CW-1:0] wcnt_inc;
  logic [CW-1:0] rcnt_inc;

  assign req_count = i_tx_start ? i_tx_count : i_rx_count;
  assign sat_count = (req_count > FULL) ? FULL : req_count;
  assign wcnt_inc  = wcnt_q + CW'(1);
  assign rcnt_inc  = rcnt_q + CW'(1);

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    wcnt_d       = wcnt_q;
    rcnt_d       = rcnt_q;
    guard_d      = guard_q;
    seen_busy_d  = seen_busy_q;
    blank_d      = blank_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    addr_d       = addr_q;
    din_d        = din_q;
    en_d         = en_q;
    done_d       = 1'b0;
    we_d         = 1'b0;
    stb_d        = 1'b0;
    cancel_stb_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_tx_start || i_rx_start) begin
          if (sat_count == '0) begin
            done_d = 1'b1;
          end else begin
            count_d = sat_count;
            if (i_tx_start) begin
              state_d    = ST_LOAD;
              in_ready_d = 1'b1;
              wcnt_d     = '0;
            end else begin
              state_d     = ST_ARM_RX;
              en_d        = 1'b1;
              guard_d     = GUARD;
              seen_busy_d = 1'b0;
            end
          end
        end
      end
      ST_LOAD: begin
        if (in_ready_q && i_in_valid) begin
          we_d   = 1'b1;
          addr_d = wcnt_q[MEM_DEPTH-1:0];
          din_d  = i_in_data;
          wcnt_d = wcnt_inc;
          if (wcnt_inc == count_q || i_in_last) begin
            state_d    = ST_FLUSH;
            in_ready_d = 1'b0;
            stb_d      = 1'b1;
            guard_d    = GUARD;
          end
        end
      end
      ST_FLUSH: begin
        if (guard_q != '0) begin
          guard_d = guard_q - GW'(1);
        end else if (idle_s) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_ARM_RX: begin
        // bridge must be seen busy before its return to idle means "filled"
        if (guard_q != '0) begin
          guard_d = guard_q - GW'(1);
        end else if (!seen_busy_q) begin
          seen_busy_d = !idle_s;
        end else if (idle_s) begin
          en_d    = 1'b0;
          rcnt_d  = '0;
          addr_d  = '0;
          blank_d = 1'b1;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_valid_q) begin
          if (i_out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            if (rcnt_inc == count_q) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              rcnt_d  = rcnt_inc;
              addr_d  = rcnt_inc[MEM_DEPTH-1:0];
              blank_d = 1'b1;
            end
          end
        end else if (blank_q) begin
          blank_d = 1'b0;
        end else if (i_bram_valid) begin
          out_valid_d = 1'b1;
          out_data_d  = i_bram_dout;
          out_last_d  = (rcnt_inc == count_q);
        end
      end
      ST_CANCEL: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // cancel overrides everything; ignored while already cancelling so the
    // abort strobe can never repeat on consecutive cycles
    if (i_cancel && state_q != ST_IDLE && state_q != ST_CANCEL) begin
      state_d      = ST_CANCEL;
      cancel_stb_d = 1'b1;
      en_d         = 1'b0;
      out_valid_d  = 1'b0;
      out_last_d   = 1'b0;
      in_ready_d   = 1'b0;
      we_d         = 1'b0;
      stb_d        = 1'b0;
      done_d       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      wcnt_q       <= '0;
      rcnt_q       <= '0;
      guard_q      <= '0;
      seen_busy_q  <= 1'b0;
      blank_q      <= 1'b0;
      done_q       <= 1'b0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      din_q        <= '0;
      stb_q        <= 1'b0;
      en_q         <= 1'b0;
      cancel_stb_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      wcnt_q       <= wcnt_d;
      rcnt_q       <= rcnt_d;
      guard_q      <= guard_d;
      seen_busy_q  <= seen_busy_d;
      blank_q      <= blank_d;
      done_q       <= done_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      stb_q        <= stb_d;
      en_q         <= en_d;
      cancel_stb_q <= cancel_stb_d;
    end
  end

  assign o_busy             = (state_q != ST_IDLE);
  assign o_done             = done_q;
  assign o_in_ready         = in_ready_q;
  assign o_out_valid        = out_valid_q;
  assign o_out_data         = out_data_q;
  assign o_out_last         = out_last_q;
  assign o_bram_we          = we_q;
  assign o_bram_addr        = addr_q;
  assign o_bram_din         = din_q;
  assign o_mem_2_ppfifo_stb = stb_q;
  assign o_ppfifo_2_mem_en  = en_q;
  assign o_cancel_write_stb = cancel_stb_q;

endmodule

// File: tb/tb_dpb_stream_loader.sv
// Directed bench for dpb_stream_loader with a small BRAM/bridge model.
module tb_dpb_stream_loader;
  import dpb_pkg::*;

  localparam int unsigned MD = 4;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_tx_start = 1'b0;
  logic [MD:0]   i_tx_count = '0;
  logic          i_rx_start = 1'b0;
  logic [MD:0]   i_rx_count = '0;
  logic          i_cancel = 1'b0;
  logic          o_busy, o_done;
  logic          i_in_valid = 1'b0;
  logic          o_in_ready;
  logic [DW-1:0] i_in_data = '0;
  logic          i_in_last = 1'b0;
  logic          o_out_valid;
  logic          i_out_ready = 1'b0;
  logic [DW-1:0] o_out_data;
  logic          o_out_last;
  logic          o_bram_we;
  logic [MD-1:0] o_bram_addr;
  logic [DW-1:0] o_bram_din;
  logic [DW-1:0] i_bram_dout = '0;
  logic          i_bram_valid = 1'b0;
  logic          o_mem_2_ppfifo_stb, o_ppfifo_2_mem_en, o_cancel_write_stb;
  logic          i_bridge_idle = 1'b1;

  dpb_stream_loader #(.MEM_DEPTH(MD), .DATA_WIDTH(DW), .IDLE_GUARD(4)) dut (
    .clk(clk), .rst(rst),
    .i_tx_start(i_tx_start), .i_tx_count(i_tx_count),
    .i_rx_start(i_rx_start), .i_rx_count(i_rx_count),
    .i_cancel(i_cancel), .o_busy(o_busy), .o_done(o_done),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_in_data(i_in_data), .i_in_last(i_in_last),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_out_data(o_out_data), .o_out_last(o_out_last),
    .o_bram_we(o_bram_we), .o_bram_addr(o_bram_addr), .o_bram_din(o_bram_din),
    .i_bram_dout(i_bram_dout), .i_bram_valid(i_bram_valid),
    .o_mem_2_ppfifo_stb(o_mem_2_ppfifo_stb), .o_ppfifo_2_mem_en(o_ppfifo_2_mem_en),
    .o_cancel_write_stb(o_cancel_write_stb), .i_bridge_idle(i_bridge_idle)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  // monitor / bridge model state (written only by the negedge process)
  logic [DW-1:0] bram [16];
  logic [DW-1:0] fill_base = 32'h10;
  logic [MD-1:0] last_addr = '0;
  int            vctr = 0;
  int            busy_ctr = 0;
  bit            en_taken = 0;
  bit            en_prev = 0;
  bit            hold_pending = 0;
  logic [DW-1:0] held_data = '0;
  logic [MD-1:0] wr_addr_log [$];
  logic [DW-1:0] wr_data_log [$];
  logic [DW-1:0] out_data_log [$];
  bit            out_last_log [$];
  int stb_cnt = 0, done_cnt = 0, cancel_cnt = 0, en_rise_cnt = 0;
  int en_overlap = 0, stab_viol = 0;

  always @(negedge clk) begin
    // BRAM read port lags an address change by one sample, then qualifies
    i_bram_dout  = bram[last_addr];
    i_bram_valid = (vctr >= int'(MEM_WAIT));
    if (o_bram_addr != last_addr) begin
      last_addr = o_bram_addr;
      vctr = 0;
    end else if (vctr < 15) begin
      vctr++;
    end
    if (o_bram_we) begin
      bram[o_bram_addr] = o_bram_din;
      wr_addr_log.push_back(o_bram_addr);
      wr_data_log.push_back(o_bram_din);
    end
    if (o_mem_2_ppfifo_stb) begin
      busy_ctr = 6;
      stb_cnt++;
    end else if (o_ppfifo_2_mem_en && !en_taken) begin
      en_taken = 1;
      busy_ctr = 10;
      for (int i = 0; i < 16; i++) bram[i] = fill_base + DW'(i);
    end else if (busy_ctr != 0) begin
      busy_ctr--;
    end
    if (!o_ppfifo_2_mem_en) en_taken = 0;
    i_bridge_idle = (busy_ctr == 0);
    if (o_done) done_cnt++;
    if (o_cancel_write_stb) cancel_cnt++;
    if (o_ppfifo_2_mem_en && !en_prev) en_rise_cnt++;
    en_prev = o_ppfifo_2_mem_en;
    if (hold_pending && (!o_out_valid || o_out_data != held_data)) stab_viol++;
    if (o_out_valid && i_out_ready) begin
      out_data_log.push_back(o_out_data);
      out_last_log.push_back(o_out_last);
      if (o_ppfifo_2_mem_en) en_overlap++;
    end
    hold_pending = o_out_valid && !i_out_ready;
    held_data = o_out_data;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int unsigned count;
    int unsigned last_beat;
    int unsigned exp_writes;
  } tx_vec_t;

  typedef struct {
    int unsigned   count;
    bit            toggle;
    logic [DW-1:0] base;
    int unsigned   exp_words;
  } rx_vec_t;

  task automatic run_tx(input string tag, input int unsigned count, input int unsigned last_beat,
                        input int unsigned exp_writes, input bit also_rx);
    int w0, s0, d0, c0, e0, o0, beat, bad;
    bit acc;
    w0 = wr_addr_log.size(); s0 = stb_cnt; d0 = done_cnt; c0 = cancel_cnt;
    e0 = en_rise_cnt; o0 = out_data_log.size();
    i_tx_count = (MD+1)'(count);
    i_rx_count = 5'd3;
    i_tx_start = 1'b1;
    i_rx_start = also_rx;
    tick();
    i_tx_start = 1'b0;
    i_rx_start = 1'b0;
    i_in_valid = 1'b1;
    beat = 0;
    for (int cyc = 0; cyc < 64; cyc++) begin
      i_in_data = 32'hA0 + DW'(beat);
      i_in_last = (last_beat != 0 && beat + 1 == int'(last_beat));
      @(negedge clk);
      acc = o_in_ready;
      if (!acc && beat > 0) break;
      tick();
      if (acc) beat++;
    end
    i_in_valid = 1'b0;
    i_in_last = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      tick();
      if (done_cnt != d0) break;
    end
    repeat (4) tick();
    check({tag, "_writes"}, wr_addr_log.size() - w0, exp_writes);
    bad = 0;
    for (int i = w0; i < wr_addr_log.size(); i++) begin
      if (wr_addr_log[i] != MD'(i - w0) || wr_data_log[i] != 32'hA0 + DW'(i - w0)) bad++;
    end
    check({tag, "_write_order"}, bad, 0);
    check({tag, "_stb"}, stb_cnt - s0, 1);
    check({tag, "_done"}, done_cnt - d0, 1);
    check({tag, "_no_cancel"}, cancel_cnt - c0, 0);
    check({tag, "_busy_end"}, o_busy, 0);
    if (also_rx) begin
      check({tag, "_rx_dropped_en"}, en_rise_cnt - e0, 0);
      check({tag, "_rx_dropped_out"}, out_data_log.size() - o0, 0);
    end
  endtask

  task automatic run_rx(input string tag, input rx_vec_t v);
    int o0, d0, e0, s0, sv0, eo0, bad;
    o0 = out_data_log.size(); d0 = done_cnt; e0 = en_rise_cnt; s0 = stb_cnt;
    sv0 = stab_viol; eo0 = en_overlap;
    fill_base = v.base;
    i_out_ready = !v.toggle;
    i_rx_count = (MD+1)'(v.count);
    i_rx_start = 1'b1;
    tick();
    i_rx_start = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      tick();
      if (v.toggle) i_out_ready = !i_out_ready;
      if (done_cnt != d0) break;
    end
    i_out_ready = 1'b0;
    repeat (4) tick();
    check({tag, "_words"}, out_data_log.size() - o0, v.exp_words);
    bad = 0;
    for (int i = o0; i < out_data_log.size(); i++) begin
      if (out_data_log[i] != v.base + DW'(i - o0)) bad++;
      if (out_last_log[i] != (i - o0 == int'(v.count) - 1)) bad++;
    end
    check({tag, "_data_last"}, bad, 0);
    check({tag, "_stable"}, stab_viol - sv0, 0);
    check({tag, "_en_before_out"}, en_overlap - eo0, 0);
    check({tag, "_en_once"}, en_rise_cnt - e0, 1);
    check({tag, "_done"}, done_cnt - d0, 1);
    check({tag, "_no_stb"}, stb_cnt - s0, 0);
    check({tag, "_en_low"}, o_ppfifo_2_mem_en, 0);
  endtask

  tx_vec_t tx_tab [3];
  rx_vec_t rx_tab [3];

  initial begin
    int c0, d0, s0, w0, beat;
    bit acc;
    tx_tab[0] = '{count: 4,  last_beat: 0, exp_writes: 4};
    tx_tab[1] = '{count: 16, last_beat: 3, exp_writes: 3};
    tx_tab[2] = '{count: 31, last_beat: 0, exp_writes: 16};
    rx_tab[0] = '{count: 4, toggle: 1'b0, base: 32'h10, exp_words: 4};
    rx_tab[1] = '{count: 4, toggle: 1'b1, base: 32'h40, exp_words: 4};
    rx_tab[2] = '{count: 7, toggle: 1'b1, base: 32'h70, exp_words: 7};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {o_busy, o_done, o_in_ready, o_out_valid, o_out_last, o_bram_we,
                         o_mem_2_ppfifo_stb, o_ppfifo_2_mem_en, o_cancel_write_stb}, 0);
    check("reset_data", {o_bram_addr, o_out_data, o_bram_din}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) tick();

    // zero count: done on the very next cycle, never busy
    i_tx_count = '0;
    i_tx_start = 1'b1;
    tick();
    i_tx_start = 1'b0;
    check("zero_done", o_done, 1);
    check("zero_busy", o_busy, 0);
    tick();
    check("zero_done_pulse", o_done, 0);
    repeat (2) tick();

    for (int r = 0; r < 3; r++)
      run_tx($sformatf("tx%0d", r), tx_tab[r].count, tx_tab[r].last_beat, tx_tab[r].exp_writes, 1'b0);

    for (int r = 0; r < 3; r++)
      run_rx($sformatf("rx%0d", r), rx_tab[r]);

    // cancel after two accepted beats
    c0 = cancel_cnt; d0 = done_cnt; s0 = stb_cnt; w0 = wr_addr_log.size();
    i_tx_count = 5'd8;
    i_tx_start = 1'b1;
    tick();
    i_tx_start = 1'b0;
    i_in_valid = 1'b1;
    beat = 0;
    for (int cyc = 0; cyc < 20 && beat < 2; cyc++) begin
      i_in_data = 32'hC0 + DW'(beat);
      @(negedge clk);
      acc = o_in_ready;
      tick();
      if (acc) beat++;
    end
    i_in_valid = 1'b0;
    i_cancel = 1'b1;
    tick();
    i_cancel = 1'b0;
    @(negedge clk);
    check("cancel_stb", {o_cancel_write_stb, o_busy, o_in_ready}, 3'b110);
    tick();
    @(negedge clk);
    check("cancel_idle", {o_busy, o_cancel_write_stb}, 2'b00);
    repeat (20) tick();
    check("cancel_count", cancel_cnt - c0, 1);
    check("cancel_no_done", done_cnt - d0, 0);
    check("cancel_no_stb", stb_cnt - s0, 0);
    check("cancel_writes", wr_addr_log.size() - w0, 2);

    // cancel while idle is ignored
    c0 = cancel_cnt;
    i_cancel = 1'b1;
    tick();
    i_cancel = 1'b0;
    repeat (3) tick();
    check("cancel_in_idle", cancel_cnt - c0, 0);
    check("cancel_in_idle_busy", o_busy, 0);

    // simultaneous starts: TX wins
    run_tx("both", 2, 0, 2, 1'b1);

    // reset during ARM_RX aborts without a cancel strobe
    c0 = cancel_cnt;
    i_rx_count = 5'd4;
    i_rx_start = 1'b1;
    tick();
    i_rx_start = 1'b0;
    repeat (2) tick();
    check("rst_mid_en", o_ppfifo_2_mem_en, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_state", {o_busy, o_ppfifo_2_mem_en}, 2'b00);
    repeat (20) tick();
    check("rst_mid_no_cancel", cancel_cnt - c0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
